memory_cycle: RTL and testbench

Memory (MEM) stage of the five-stage RISC-V pipeline, directly upstream of the writeback stage. It performs data-memory loads and stores, including byte, halfword and word accesses with sign or zero extension. It registers the MEM/WB pipeline values that the writeback stage's result mux consumes. It contains the data memory as one sub-module.

---
 rtl/memory_cycle_pkg.sv | 13 +
 rtl/memory_cycle_data_memory.sv | 29 ++
 rtl/memory_cycle.sv | 117 +++++++++++
 tb/tb_memory_cycle.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_cycle_pkg.sv
// Shared definitions for the MEM stage: load/store size encodings and MEM/WB field widths.
package memory_cycle_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

endpackage

// File: rtl/memory_cycle_data_memory.sv
// Word-organised data memory: combinational read, synchronous byte-enabled write, no reset.
module data_memory
  import memory_cycle_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              writeEn,
  input  logic [3:0]        byteEn,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign readData = mem[addr];

  // Each enabled lane is written independently so unselected bytes keep their old value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (writeEn && byteEn[i]) begin
        mem[addr][8*i +: 8] <= writeData[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// MEM stage: store lane alignment, load extension, misalignment detection and the MEM/WB register.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [2:0]        funct3M,
  input  logic [REG_W-1:0]  RDM,
  input  logic [DATA_W-1:0] ALU_ResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] PCPlus4M,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [REG_W-1:0]  RDW,
  output logic [DATA_W-1:0] ALU_ResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] PCPlus4W,
  output logic              MisalignW
);

  logic [AW-1:0]     wordIdx;
  logic [1:0]        offset;
  logic              sizeMisalign;
  logic              misalign;
  logic              memWriteEn;
  logic [3:0]        byteEn;
  logic [DATA_W-1:0] storeData;
  logic [DATA_W-1:0] rawRead;
  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;
  logic [DATA_W-1:0] loadData;
  logic              unusedAddrBits;

  assign wordIdx        = ALU_ResultM[AW+1:2];
  assign offset         = ALU_ResultM[1:0];
  assign unusedAddrBits = ^ALU_ResultM[DATA_W-1:AW+2];

  // Undefined funct3 encodings fall into the word case for alignment, lanes and extension.
  always_comb begin
    sizeMisalign = 1'b0;
    byteEn       = 4'b1111;
    storeData    = WriteDataM;
    case (funct3M)
      F3_B, F3_BU: begin
        byteEn    = 4'b0001 << offset;
        storeData = {4{WriteDataM[7:0]}};
      end
      F3_H, F3_HU: begin
        sizeMisalign = offset[0];
        byteEn       = 4'b0011 << offset;
        storeData    = {2{WriteDataM[15:0]}};
      end
      default: sizeMisalign = (offset != 2'b00);
    endcase
  end

  assign misalign   = (MemWriteM || ResultSrcM) && sizeMisalign;
  assign memWriteEn = MemWriteM && !misalign && rst;

  data_memory #(.DEPTH(DEPTH), .AW(AW)) uDataMemory (
    .clk       (clk),
    .writeEn   (memWriteEn),
    .byteEn    (byteEn),
    .addr      (wordIdx),
    .writeData (storeData),
    .readData  (rawRead)
  );

  always_comb begin
    loadByte = rawRead[7:0];
    case (offset)
      2'd1:    loadByte = rawRead[15:8];
      2'd2:    loadByte = rawRead[23:16];
      2'd3:    loadByte = rawRead[31:24];
      default: loadByte = rawRead[7:0];
    endcase
    loadHalf = offset[1] ? rawRead[31:16] : rawRead[15:0];
    case (funct3M)
      F3_B:    loadData = {{24{loadByte[7]}}, loadByte};
      F3_BU:   loadData = {24'd0, loadByte};
      F3_H:    loadData = {{16{loadHalf[15]}}, loadHalf};
      F3_HU:   loadData = {16'd0, loadHalf};
      default: loadData = rawRead;
    endcase
    if (ResultSrcM && misalign) begin
      loadData = '0;
    end
  end

  // A misaligned load must not reach the register file, so its write enable is dropped here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RDW         <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
      MisalignW   <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM && !(ResultSrcM && misalign);
      ResultSrcW  <= ResultSrcM;
      RDW         <= RDM;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= loadData;
      PCPlus4W    <= PCPlus4M;
      MisalignW   <= misalign;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed self-checking bench for memory_cycle: loads, stores, extension, misalignment and reset.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
  logic [2:0]  funct3M = 3'b010;
  logic [4:0]  RDM = '0;
  logic [31:0] ALU_ResultM = '0, WriteDataM = '0, PCPlus4M = '0;
  logic        RegWriteW, ResultSrcW, MisalignW;
  logic [4:0]  RDW;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;

  int checks = 0;
  int errors = 0;

  memory_cycle dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RDM(RDM), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .RDW(RDW), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  // Present one instruction to MEM, then sample W one time unit after the capturing edge.
  task automatic drive(input logic rw, input logic mw, input logic rs, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; funct3M = f3;
    RDM = rd; ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 0, 1, 3'b010, 5'd3, 32'h10, 32'h0, 32'h8);
    drive(1, 0, 1, 3'b010, 5'd3, 32'h10, 32'h0, 32'h8);
    checks++;
    if ({RegWriteW, ResultSrcW, RDW, ALU_ResultW, ReadDataW, PCPlus4W, MisalignW} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state got rw=%b rs=%b rd=%0d alu=%h rdata=%h pc=%h mis=%b want all zero",
               RegWriteW, ResultSrcW, RDW, ALU_ResultW, ReadDataW, PCPlus4W, MisalignW);
    end
    rst = 1'b1;
  endtask

  task automatic test_word_roundtrip();
    drive(0, 1, 0, 3'b010, 5'd0, 32'h10, 32'hDEADBEEF, 32'h4);
    checks++;
    if (RegWriteW !== 1'b0 || MisalignW !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sw_word_flags got rw=%b mis=%b want rw=0 mis=0", RegWriteW, MisalignW);
    end
    drive(1, 0, 1, 3'b010, 5'd10, 32'h10, 32'h0, 32'h8);
    checks++;
    if (ReadDataW !== 32'hDEADBEEF || RegWriteW !== 1'b1 || ResultSrcW !== 1'b1 || RDW !== 5'd10) begin
      errors++;
      $display("[TB] FAIL lw_word got data=%h rw=%b rs=%b rd=%0d want data=deadbeef rw=1 rs=1 rd=10",
               ReadDataW, RegWriteW, ResultSrcW, RDW);
    end
  endtask

  task automatic test_subword_extend();
    drive(0, 1, 0, 3'b010, 5'd0, 32'h20, 32'h80FF7F01, 32'h4);
    drive(1, 0, 1, 3'b000, 5'd1, 32'h23, 32'h0, 32'h8);
    checks++;
    if (ReadDataW !== 32'hFFFFFF80) begin
      errors++; $display("[TB] FAIL lb_0x23 got %h want ffffff80", ReadDataW);
    end
    drive(1, 0, 1, 3'b100, 5'd1, 32'h23, 32'h0, 32'h8);
    checks++;
    if (ReadDataW !== 32'h00000080) begin
      errors++; $display("[TB] FAIL lbu_0x23 got %h want 00000080", ReadDataW);
    end
    drive(1, 0, 1, 3'b001, 5'd1, 32'h22, 32'h0, 32'h8);
    checks++;
    if (ReadDataW !== 32'hFFFF80FF) begin
      errors++; $display("[TB] FAIL lh_0x22 got %h want ffff80ff", ReadDataW);
    end
    drive(1, 0, 1, 3'b101, 5'd1, 32'h20, 32'h0, 32'h8);
    checks++;
    if (ReadDataW !== 32'h00007F01) begin
      errors++; $display("[TB] FAIL lhu_0x20 got %h want 00007f01", ReadDataW);
    end
    drive(1, 0, 1, 3'b000, 5'd1, 32'h21, 32'h0, 32'h8);
    checks++;
    if (ReadDataW !== 32'h0000007F) begin
      errors++; $display("[TB] FAIL lb_0x21 got %h want 0000007f", ReadDataW);
    end
  endtask

  task automatic test_partial_store();
    drive(0, 1, 0, 3'b010, 5'd0, 32'h30, 32'h11223344, 32'h4);
    drive(0, 1, 0, 3'b000, 5'd0, 32'h31, 32'h123456AA, 32'h4);
    drive(0, 1, 0, 3'b001, 5'd0, 32'h32, 32'hCAFEBEEF, 32'h4);
    drive(1, 0, 1, 3'b010, 5'd2, 32'h30, 32'h0, 32'h8);
    checks++;
    if (ReadDataW !== 32'hBEEFAA44) begin
      errors++; $display("[TB] FAIL partial_store got %h want beefaa44", ReadDataW);
    end
  endtask

  task automatic test_misalign();
    drive(0, 1, 0, 3'b010, 5'd0, 32'h40, 32'hCAFEF00D, 32'h4);
    drive(1, 0, 1, 3'b010, 5'd4, 32'h41, 32'h0, 32'h8);
    checks++;
    if (MisalignW !== 1'b1 || RegWriteW !== 1'b0 || ReadDataW !== 32'h0) begin
      errors++;
      $display("[TB] FAIL lw_misaligned got mis=%b rw=%b data=%h want mis=1 rw=0 data=0",
               MisalignW, RegWriteW, ReadDataW);
    end
    drive(0, 1, 0, 3'b001, 5'd0, 32'h43, 32'h0000FFFF, 32'h4);
    checks++;
    if (MisalignW !== 1'b1) begin
      errors++; $display("[TB] FAIL sh_misaligned_flag got %b want 1", MisalignW);
    end
    drive(0, 1, 0, 3'b010, 5'd0, 32'h42, 32'h01234567, 32'h4);
    drive(1, 0, 1, 3'b010, 5'd4, 32'h40, 32'h0, 32'h8);
    checks++;
    if (ReadDataW !== 32'hCAFEF00D || MisalignW !== 1'b0) begin
      errors++; $display("[TB] FAIL misaligned_store_kept got %h mis=%b want cafef00d mis=0", ReadDataW, MisalignW);
    end
    drive(1, 0, 1, 3'b001, 5'd4, 32'h41, 32'h0, 32'h8);
    checks++;
    if (MisalignW !== 1'b1 || RegWriteW !== 1'b0 || ReadDataW !== 32'h0) begin
      errors++;
      $display("[TB] FAIL lh_misaligned got mis=%b rw=%b data=%h want mis=1 rw=0 data=0",
               MisalignW, RegWriteW, ReadDataW);
    end
    drive(1, 0, 1, 3'b000, 5'd4, 32'h41, 32'h0, 32'h8);
    checks++;
    if (MisalignW !== 1'b0 || RegWriteW !== 1'b1 || ReadDataW !== 32'hFFFFFFF0) begin
      errors++;
      $display("[TB] FAIL lb_odd_aligned got mis=%b rw=%b data=%h want mis=0 rw=1 data=fffffff0",
               MisalignW, RegWriteW, ReadDataW);
    end
    drive(1, 0, 0, 3'b000, 5'd6, 32'h41, 32'h0, 32'h8);
    checks++;
    if (MisalignW !== 1'b0 || RegWriteW !== 1'b1) begin
      errors++; $display("[TB] FAIL add_unaligned got mis=%b rw=%b want mis=0 rw=1", MisalignW, RegWriteW);
    end
  endtask

  task automatic test_pass_through();
    drive(1, 0, 0, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h104);
    checks++;
    if (RDW !== 5'd5 || ALU_ResultW !== 32'h1234 || PCPlus4W !== 32'h104 || ResultSrcW !== 1'b0 ||
        RegWriteW !== 1'b1 || MisalignW !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pass_through got rd=%0d alu=%h pc=%h rs=%b rw=%b mis=%b want rd=5 alu=1234 pc=104 rs=0 rw=1 mis=0",
               RDW, ALU_ResultW, PCPlus4W, ResultSrcW, RegWriteW, MisalignW);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 1, 3'b010, 5'd0, 32'h10, 32'h00000099, 32'h4);
    checks++;
    if (ReadDataW !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL store_load_predata got %h want deadbeef", ReadDataW);
    end
    drive(1, 0, 1, 3'b010, 5'd7, 32'h1010, 32'h0, 32'h8);
    checks++;
    if (ReadDataW !== 32'h00000099) begin
      errors++; $display("[TB] FAIL wrapped_load got %h want 00000099", ReadDataW);
    end
  endtask

  task automatic test_reset_midstream();
    drive(0, 1, 0, 3'b010, 5'd0, 32'h50, 32'h12345678, 32'h4);
    drive(1, 0, 1, 3'b010, 5'd9, 32'h50, 32'h0, 32'h20);
    rst = 1'b0;
    drive(1, 1, 0, 3'b010, 5'd9, 32'h50, 32'h00000055, 32'h24);
    checks++;
    if ({RegWriteW, ResultSrcW, RDW, ALU_ResultW, ReadDataW, PCPlus4W, MisalignW} !== '0) begin
      errors++;
      $display("[TB] FAIL midstream_reset got rw=%b rs=%b rd=%0d alu=%h rdata=%h pc=%h mis=%b want all zero",
               RegWriteW, ResultSrcW, RDW, ALU_ResultW, ReadDataW, PCPlus4W, MisalignW);
    end
    rst = 1'b1;
    drive(1, 0, 1, 3'b010, 5'd11, 32'h50, 32'h0, 32'h28);
    checks++;
    if (ReadDataW !== 32'h12345678 || RegWriteW !== 1'b1 || RDW !== 5'd11 || PCPlus4W !== 32'h28) begin
      errors++;
      $display("[TB] FAIL post_reset_load got data=%h rw=%b rd=%0d pc=%h want data=12345678 rw=1 rd=11 pc=28",
               ReadDataW, RegWriteW, RDW, PCPlus4W);
    end
  endtask

  initial begin
    test_reset();
    test_word_roundtrip();
    test_subword_extend();
    test_partial_store();
    test_misalign();
    test_pass_through();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
